// File: rtl/data_memory_pkg.sv
// Shared constants, width helpers and FSM encoding for the banked data memory.
package data_memory_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Number of byte-offset bits inside one word.
  function automatic int offset_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Number of bits needed to index every word of the memory.
  function automatic int index_bits(input int depth);
    return $clog2(depth);
  endfunction

  // Number of low index bits that select the bank.
  function automatic int bank_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  // Number of index bits that select the row inside a bank.
  function automatic int row_bits(input int depth, input int num_banks);
    return $clog2(depth / num_banks);
  endfunction

endpackage

// File: rtl/banked_data_memory_if.sv
// One load/store port of the banked data memory: request side plus response side.
interface banked_data_memory_if #(
  parameter int DATA_WIDTH = 32
);
  import data_memory_pkg::*;

  logic                      req;
  logic                      write;
  logic [DATA_WIDTH/8-1:0]   byte_en;
  logic [ADDR_WIDTH-1:0]     address;
  logic [DATA_WIDTH-1:0]     write_data;
  logic                      ready;
  logic                      rvalid;
  logic [DATA_WIDTH-1:0]     read_data;

  modport master (
    output req, write, byte_en, address, write_data,
    input  ready, rvalid, read_data
  );

  modport slave (
    input  req, write, byte_en, address, write_data,
    output ready, rvalid, read_data
  );

endinterface

// File: rtl/banked_data_memory_bank.sv
// Single-port synchronous RAM bank with byte-lane writes and a registered read port.
module mem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 256,
  parameter int ROW_W      = 8
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ROW_W-1:0]        row,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_r [ROWS];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Byte-lane write: only enabled lanes of the addressed row are updated.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_r[row][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Registered read returns the row contents as they were before this edge.
  always_ff @(posedge clk) begin
    if (en && !we) begin
      rdata_r <= mem_r[row];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/banked_data_memory.sv
// Two-port word-interleaved banked data memory with rotating-priority bank
// arbitration and a post-reset zero-fill sweep.
module banked_data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int NUM_BANKS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  banked_data_memory_if.slave   port0,
  banked_data_memory_if.slave   port1,
  output logic                  init_done
);

  localparam int OFF_W  = offset_bits(DATA_WIDTH);
  localparam int IDX_W  = index_bits(DEPTH);
  localparam int BANK_W = bank_bits(NUM_BANKS);
  localparam int ROW_W  = row_bits(DEPTH, NUM_BANKS);
  localparam int ROWS   = DEPTH / NUM_BANKS;
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t                 state_r;
  logic [ROW_W-1:0]       row_cnt_r;
  logic                   prio_r;

  logic [1:0]             req_s;
  logic [1:0]             write_s;
  logic [IDX_W-1:0]       index_s    [2];
  logic [BANK_W-1:0]      bank_s     [2];
  logic [ROW_W-1:0]       row_s      [2];
  logic [BE_W-1:0]        be_s       [2];
  logic [DATA_WIDTH-1:0]  wdata_s    [2];
  logic                   conflict_s;
  logic [1:0]             ready_s;

  logic [1:0]             rvalid_r;
  logic [BANK_W-1:0]      bank_sel_r [2];
  logic [DATA_WIDTH-1:0]  held_r     [2];
  logic [DATA_WIDTH-1:0]  mux_s      [2];

  logic                   bank_en_s    [NUM_BANKS];
  logic                   bank_we_s    [NUM_BANKS];
  logic [BE_W-1:0]        bank_be_s    [NUM_BANKS];
  logic [ROW_W-1:0]       bank_row_s   [NUM_BANKS];
  logic [DATA_WIDTH-1:0]  bank_wdata_s [NUM_BANKS];
  logic [DATA_WIDTH-1:0]  bank_rdata_s [NUM_BANKS];

  // Address decode: byte offset dropped, upper bits wrap modulo DEPTH.
  assign req_s      = {port1.req, port0.req};
  assign write_s    = {port1.write, port0.write};
  assign index_s[0] = port0.address[OFF_W +: IDX_W];
  assign index_s[1] = port1.address[OFF_W +: IDX_W];
  assign bank_s[0]  = index_s[0][BANK_W-1:0];
  assign bank_s[1]  = index_s[1][BANK_W-1:0];
  assign row_s[0]   = index_s[0][IDX_W-1:BANK_W];
  assign row_s[1]   = index_s[1][IDX_W-1:BANK_W];
  assign be_s[0]    = port0.byte_en;
  assign be_s[1]    = port1.byte_en;
  assign wdata_s[0] = port0.write_data;
  assign wdata_s[1] = port1.write_data;

  // Arbiter: on a same-bank collision only the port holding priority proceeds.
  always_comb begin
    conflict_s = 1'b0;
    ready_s    = 2'b00;
    if (state_r == RUN && !reset) begin
      conflict_s = req_s[0] & req_s[1] & (bank_s[0] == bank_s[1]);
      ready_s[0] = req_s[0] & (~conflict_s | ~prio_r);
      ready_s[1] = req_s[1] & (~conflict_s |  prio_r);
    end else begin
      conflict_s = 1'b0;
      ready_s    = 2'b00;
    end
  end

  // Bank input steering: clear sweep owns every bank, otherwise the granted port.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_en_s[b]    = 1'b0;
      bank_we_s[b]    = 1'b0;
      bank_be_s[b]    = {BE_W{1'b0}};
      bank_row_s[b]   = {ROW_W{1'b0}};
      bank_wdata_s[b] = {DATA_WIDTH{1'b0}};
      if (state_r == CLEAR) begin
        bank_en_s[b]  = 1'b1;
        bank_we_s[b]  = 1'b1;
        bank_be_s[b]  = {BE_W{1'b1}};
        bank_row_s[b] = row_cnt_r;
      end else if (ready_s[0] && bank_s[0] == BANK_W'(b)) begin
        bank_en_s[b]    = 1'b1;
        bank_we_s[b]    = write_s[0];
        bank_be_s[b]    = be_s[0];
        bank_row_s[b]   = row_s[0];
        bank_wdata_s[b] = wdata_s[0];
      end else if (ready_s[1] && bank_s[1] == BANK_W'(b)) begin
        bank_en_s[b]    = 1'b1;
        bank_we_s[b]    = write_s[1];
        bank_be_s[b]    = be_s[1];
        bank_row_s[b]   = row_s[1];
        bank_wdata_s[b] = wdata_s[1];
      end else begin
        bank_en_s[b]    = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROWS       (ROWS),
      .ROW_W      (ROW_W)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en_s[g]),
      .we    (bank_we_s[g]),
      .be    (bank_be_s[g]),
      .row   (bank_row_s[g]),
      .wdata (bank_wdata_s[g]),
      .rdata (bank_rdata_s[g])
    );
  end

  // Clear/run FSM with sweep row counter and conflict priority toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= CLEAR;
      row_cnt_r <= {ROW_W{1'b0}};
      prio_r    <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          if (row_cnt_r == LAST_ROW) begin
            state_r   <= RUN;
            row_cnt_r <= {ROW_W{1'b0}};
          end else begin
            row_cnt_r <= row_cnt_r + ROW_W'(1);
          end
        end
        RUN: begin
          if (conflict_s) begin
            prio_r <= ~prio_r;
          end
        end
        default: begin
          state_r   <= CLEAR;
          row_cnt_r <= {ROW_W{1'b0}};
        end
      endcase
    end
  end

  // Per-port response tracking: load valid, which bank answers, last delivered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_r <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        bank_sel_r[p] <= {BANK_W{1'b0}};
        held_r[p]     <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        rvalid_r[p] <= ready_s[p] & ~write_s[p];
        if (ready_s[p] && !write_s[p]) begin
          bank_sel_r[p] <= bank_s[p];
        end
        if (rvalid_r[p]) begin
          held_r[p] <= mux_s[p];
        end
      end
    end
  end

  // Output mux picks the answering bank's read register; otherwise hold the last word.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      mux_s[p] = bank_rdata_s[bank_sel_r[p]];
    end
  end

  assign port0.ready     = ready_s[0];
  assign port1.ready     = ready_s[1];
  assign port0.rvalid    = rvalid_r[0];
  assign port1.rvalid    = rvalid_r[1];
  assign port0.read_data = rvalid_r[0] ? mux_s[0] : held_r[0];
  assign port1.read_data = rvalid_r[1] ? mux_s[1] : held_r[1];
  assign init_done       = (state_r == RUN);

endmodule

// File: tb/tb_banked_data_memory.sv
// Directed self-checking bench for banked_data_memory.
module tb_banked_data_memory;

  logic clk = 1'b0;
  logic reset;
  logic init_done;
  int   checks = 0;
  int   errors = 0;

  banked_data_memory_if #(.DATA_WIDTH(32)) p0 ();
  banked_data_memory_if #(.DATA_WIDTH(32)) p1 ();

  banked_data_memory #(
    .DATA_WIDTH (32),
    .DEPTH      (1024),
    .NUM_BANKS  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .port0     (p0.slave),
    .port1     (p1.slave),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd);
    p0.req = req; p0.write = wr; p0.byte_en = be; p0.address = addr; p0.write_data = wd;
  endtask

  task automatic drive1(input logic req, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd);
    p1.req = req; p1.write = wr; p1.byte_en = be; p1.address = addr; p1.write_data = wd;
  endtask

  // Port 0 keeps a load request up for the whole sweep; it must never be accepted.
  task automatic sweep_check(input string tag);
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i < 256) begin
        chk({tag, "_init_low"}, {31'd0, init_done}, 32'd0);
        chk({tag, "_ready_low"}, {31'd0, p0.ready}, 32'd0);
      end else begin
        chk({tag, "_init_high"}, {31'd0, init_done}, 32'd1);
        chk({tag, "_ready_run"}, {31'd0, p0.ready}, 32'd1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    step();
    chk("rst_ready0", {31'd0, p0.ready}, 32'd0);
    chk("rst_rvalid0", {31'd0, p0.rvalid}, 32'd0);
    chk("rst_rvalid1", {31'd0, p1.rvalid}, 32'd0);
    chk("rst_rdata0", p0.read_data, 32'h0);
    chk("rst_rdata1", p1.read_data, 32'h0);
    chk("rst_init", {31'd0, init_done}, 32'd0);

    // Sweep with a pending load on port 0.
    drive0(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b0;
    sweep_check("sweep1");

    // Load @0 after the sweep.
    step();
    chk("ld0_rvalid", {31'd0, p0.rvalid}, 32'd1);
    chk("ld0_data", p0.read_data, 32'h0);

    // Loads @0xFFC (bank 3) and @0x1000 (wraps to word 0, bank 0).
    drive0(1'b1, 1'b0, 4'h0, 32'h0000_0FFC, 32'h0);
    drive1(1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0);
    #1;
    chk("wrap_ready0", {31'd0, p0.ready}, 32'd1);
    chk("wrap_ready1", {31'd0, p1.ready}, 32'd1);
    step();
    chk("ldffc_rvalid", {31'd0, p0.rvalid}, 32'd1);
    chk("ldffc_data", p0.read_data, 32'h0);
    chk("ld1000_rvalid", {31'd0, p1.rvalid}, 32'd1);
    chk("ld1000_data", p1.read_data, 32'h0);

    // Simultaneous stores to banks 0 and 1.
    drive0(1'b1, 1'b1, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF);
    drive1(1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'h0FFF_FFFF);
    #1;
    chk("st_ready0", {31'd0, p0.ready}, 32'd1);
    chk("st_ready1", {31'd0, p1.ready}, 32'd1);
    step();
    chk("st_no_rvalid0", {31'd0, p0.rvalid}, 32'd0);
    chk("st_no_rvalid1", {31'd0, p1.rvalid}, 32'd0);

    drive0(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
    drive1(1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    step();
    chk("rb0_rvalid", {31'd0, p0.rvalid}, 32'd1);
    chk("rb0_data", p0.read_data, 32'hFFFF_FFFF);
    chk("rb1_rvalid", {31'd0, p1.rvalid}, 32'd1);
    chk("rb1_data", p1.read_data, 32'h0FFF_FFFF);

    // Byte-masked stores @0x8.
    drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive0(1'b1, 1'b1, 4'hF, 32'h0000_0008, 32'hAABB_CCDD);
    step();
    drive0(1'b1, 1'b1, 4'h5, 32'h0000_0008, 32'h1122_3344);
    step();
    drive0(1'b1, 1'b1, 4'h0, 32'h0000_0008, 32'hDEAD_BEEF);
    step();
    chk("be0_no_rvalid", {31'd0, p0.rvalid}, 32'd0);
    chk("hold_data0", p0.read_data, 32'hFFFF_FFFF);
    drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
    step();
    chk("mask_rvalid", {31'd0, p1.rvalid}, 32'd1);
    chk("mask_data", p1.read_data, 32'hAA22_CC44);
    drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("idle_rvalid1", {31'd0, p1.rvalid}, 32'd0);
    chk("idle_hold1", p1.read_data, 32'hAA22_CC44);

    // Word @0xC = 0x000F_FFFF, then a request with write=0 is a load.
    drive0(1'b1, 1'b1, 4'hF, 32'h0000_000C, 32'h000F_FFFF);
    step();
    drive0(1'b1, 1'b0, 4'hF, 32'h0000_000C, 32'h1234_5678);
    step();
    chk("wr0_rvalid", {31'd0, p0.rvalid}, 32'd1);
    chk("wr0_data", p0.read_data, 32'h000F_FFFF);

    // Distinct value @0x10 (bank 0, row 1) for the conflict test.
    drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'h5566_7788);
    step();

    // Bank-0 conflict held three cycles: port 0, then port 1, then port 0.
    drive0(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
    drive1(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    #1;
    chk("cf1_ready0", {31'd0, p0.ready}, 32'd1);
    chk("cf1_ready1", {31'd0, p1.ready}, 32'd0);
    step();
    chk("cf1_rvalid0", {31'd0, p0.rvalid}, 32'd1);
    chk("cf1_data0", p0.read_data, 32'hFFFF_FFFF);
    chk("cf1_rvalid1", {31'd0, p1.rvalid}, 32'd0);
    chk("cf2_ready0", {31'd0, p0.ready}, 32'd0);
    chk("cf2_ready1", {31'd0, p1.ready}, 32'd1);
    step();
    chk("cf2_rvalid1", {31'd0, p1.rvalid}, 32'd1);
    chk("cf2_data1", p1.read_data, 32'h5566_7788);
    chk("cf2_rvalid0", {31'd0, p0.rvalid}, 32'd0);
    chk("cf3_ready0", {31'd0, p0.ready}, 32'd1);
    chk("cf3_ready1", {31'd0, p1.ready}, 32'd0);
    step();
    chk("cf3_rvalid0", {31'd0, p0.rvalid}, 32'd1);
    chk("cf3_rvalid1", {31'd0, p1.rvalid}, 32'd0);

    // Reset while in RUN with a load just delivered and still requested.
    drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("pre_rst_rvalid0", {31'd0, p0.rvalid}, 32'd1);
    reset = 1'b1;
    step();
    chk("run_rst_rvalid0", {31'd0, p0.rvalid}, 32'd0);
    chk("run_rst_ready0", {31'd0, p0.ready}, 32'd0);
    chk("run_rst_rdata0", p0.read_data, 32'h0);
    chk("run_rst_init", {31'd0, init_done}, 32'd0);

    // Partial sweep of 100 cycles, then reset mid-sweep: full sweep must restart.
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
    end
    chk("mid_init", {31'd0, init_done}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sweep_check("sweep2");

    // Previously stored words now read back as zero.
    drive1(1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    step();
    chk("clr0_rvalid", {31'd0, p0.rvalid}, 32'd1);
    chk("clr0_data", p0.read_data, 32'h0);
    chk("clr4_rvalid", {31'd0, p1.rvalid}, 32'd1);
    chk("clr4_data", p1.read_data, 32'h0);
    drive0(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
    drive1(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    step();
    chk("clr8_data", p0.read_data, 32'h0);
    chk("clr10_data", p1.read_data, 32'h0);
    drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
